// File: rtl/nibble_checker_if.sv
// Compare-port bundle for nibble_checker: the two words under test, the enable,
// and the registered verdict/statistics returned by the checker.
interface nibble_checker_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
);
  logic             CHECK_EN;
  logic [WIDTH-1:0] DATA_OUT_c;
  logic [WIDTH-1:0] DATA_OUT_e;
  logic             check_data_out;
  logic             error_sticky;
  logic [CNT_W-1:0] mismatch_count;
  logic [CNT_W-1:0] compare_count;
  logic [WIDTH-1:0] first_c;
  logic [WIDTH-1:0] first_e;
  logic [CNT_W-1:0] first_idx;

  modport master (
    output CHECK_EN, DATA_OUT_c, DATA_OUT_e,
    input  check_data_out, error_sticky, mismatch_count, compare_count,
           first_c, first_e, first_idx
  );

  modport slave (
    input  CHECK_EN, DATA_OUT_c, DATA_OUT_e,
    output check_data_out, error_sticky, mismatch_count, compare_count,
           first_c, first_e, first_idx
  );
endinterface

// File: rtl/nibble_checker.sv
// Compares a behavioural word against a structural word each enabled cycle and
// keeps saturating match statistics plus a capture of the first mismatch.
module nibble_checker #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input logic             CLK,
  input logic             RESET,
  nibble_checker_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             match_c;
  logic             chk_q;
  logic             sticky_q;
  logic [CNT_W-1:0] mis_cnt_q;
  logic [CNT_W-1:0] cmp_cnt_q;
  logic [WIDTH-1:0] first_c_q;
  logic [WIDTH-1:0] first_e_q;
  logic [CNT_W-1:0] first_idx_q;

  always_comb begin
    match_c = (bus.DATA_OUT_c == bus.DATA_OUT_e);
  end

  // Statistics update; capture uses the pre-increment compare count as the index.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      chk_q       <= 1'b0;
      sticky_q    <= 1'b0;
      mis_cnt_q   <= '0;
      cmp_cnt_q   <= '0;
      first_c_q   <= '0;
      first_e_q   <= '0;
      first_idx_q <= '0;
    end else if (bus.CHECK_EN) begin
      chk_q <= match_c;
      if (cmp_cnt_q != CNT_MAX) begin
        cmp_cnt_q <= cmp_cnt_q + CNT_ONE;
      end
      if (!match_c) begin
        sticky_q <= 1'b1;
        if (mis_cnt_q != CNT_MAX) begin
          mis_cnt_q <= mis_cnt_q + CNT_ONE;
        end
        if (!sticky_q) begin
          first_c_q   <= bus.DATA_OUT_c;
          first_e_q   <= bus.DATA_OUT_e;
          first_idx_q <= cmp_cnt_q;
        end
      end
    end
  end

  assign bus.check_data_out = chk_q;
  assign bus.error_sticky   = sticky_q;
  assign bus.mismatch_count = mis_cnt_q;
  assign bus.compare_count  = cmp_cnt_q;
  assign bus.first_c        = first_c_q;
  assign bus.first_e        = first_e_q;
  assign bus.first_idx      = first_idx_q;

endmodule

// File: tb/tb_nibble_checker.sv
// Bench for nibble_checker: two instances (16-bit and 4-bit counters) share the
// same stimulus and are checked against an unbounded-count reference model.
module tb_nibble_checker;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_A = 16;
  localparam int unsigned CNT_B = 4;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  nibble_checker_if #(.WIDTH(WIDTH), .CNT_W(CNT_A)) bus_a ();
  nibble_checker_if #(.WIDTH(WIDTH), .CNT_W(CNT_B)) bus_b ();

  nibble_checker #(.WIDTH(WIDTH), .CNT_W(CNT_A)) dut_a (
    .CLK(CLK), .RESET(RESET), .bus(bus_a.slave)
  );
  nibble_checker #(.WIDTH(WIDTH), .CNT_W(CNT_B)) dut_b (
    .CLK(CLK), .RESET(RESET), .bus(bus_b.slave)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: plain integer counts, clamped only when compared.
  bit     m_chk, m_seen;
  longint m_comp, m_mis, m_fidx;
  int     m_fc, m_fe;

  function automatic longint clamp(longint v, int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(bit rst, bit en, int c, int e);
    if (rst) begin
      m_chk = 0; m_seen = 0; m_comp = 0; m_mis = 0; m_fidx = 0; m_fc = 0; m_fe = 0;
    end else if (en) begin
      m_chk = (c == e);
      if (c != e) begin
        if (!m_seen) begin
          m_seen = 1; m_fc = c; m_fe = e; m_fidx = m_comp;
        end
        m_mis++;
      end
      m_comp++;
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".a.chk"},   32'(bus_a.check_data_out), 32'(m_chk));
    chk({tag, ".a.stk"},   32'(bus_a.error_sticky),   32'(m_seen));
    chk({tag, ".a.mis"},   32'(bus_a.mismatch_count), 32'(clamp(m_mis, CNT_A)));
    chk({tag, ".a.cmp"},   32'(bus_a.compare_count),  32'(clamp(m_comp, CNT_A)));
    chk({tag, ".a.fc"},    32'(bus_a.first_c),        32'(m_fc));
    chk({tag, ".a.fe"},    32'(bus_a.first_e),        32'(m_fe));
    chk({tag, ".a.fidx"},  32'(bus_a.first_idx),      32'(clamp(m_fidx, CNT_A)));
    chk({tag, ".b.chk"},   32'(bus_b.check_data_out), 32'(m_chk));
    chk({tag, ".b.stk"},   32'(bus_b.error_sticky),   32'(m_seen));
    chk({tag, ".b.mis"},   32'(bus_b.mismatch_count), 32'(clamp(m_mis, CNT_B)));
    chk({tag, ".b.cmp"},   32'(bus_b.compare_count),  32'(clamp(m_comp, CNT_B)));
    chk({tag, ".b.fc"},    32'(bus_b.first_c),        32'(m_fc));
    chk({tag, ".b.fe"},    32'(bus_b.first_e),        32'(m_fe));
    chk({tag, ".b.fidx"},  32'(bus_b.first_idx),      32'(clamp(m_fidx, CNT_B)));
  endtask

  task automatic step(string tag, bit rst, bit en, logic [3:0] c, logic [3:0] e);
    RESET = rst;
    bus_a.CHECK_EN = en; bus_a.DATA_OUT_c = c; bus_a.DATA_OUT_e = e;
    bus_b.CHECK_EN = en; bus_b.DATA_OUT_c = c; bus_b.DATA_OUT_e = e;
    @(posedge CLK);
    model_update(rst, en, int'(c), int'(e));
    @(negedge CLK);
    check_all(tag);
  endtask

  initial begin
    logic [3:0] rc, re;
    bit         ren, rrst;

    // Reset with arbitrary inputs
    step("rst0", 1, 1, 4'h3, 4'hA);
    step("rst1", 1, 0, 4'h7, 4'h1);
    chk("rst.cmp_zero", 32'(bus_a.compare_count), 32'd0);
    chk("rst.stk_zero", 32'(bus_a.error_sticky), 32'd0);

    // Three matching compares
    for (int i = 0; i < 3; i++) step("match", 0, 1, 4'hD, 4'hD);
    chk("match.chk", 32'(bus_a.check_data_out), 32'd1);
    chk("match.cmp", 32'(bus_a.compare_count), 32'd3);
    chk("match.mis", 32'(bus_a.mismatch_count), 32'd0);

    // Two mismatches; only the first is captured
    step("mis1", 0, 1, 4'hD, 4'h5);
    step("mis2", 0, 1, 4'hF, 4'h0);
    chk("mis.chk",  32'(bus_a.check_data_out), 32'd0);
    chk("mis.cnt",  32'(bus_a.mismatch_count), 32'd2);
    chk("mis.stk",  32'(bus_a.error_sticky), 32'd1);
    chk("mis.fc",   32'(bus_a.first_c), 32'hD);
    chk("mis.fe",   32'(bus_a.first_e), 32'h5);
    chk("mis.fidx", 32'(bus_a.first_idx), 32'd3);
    chk("mis.cmp",  32'(bus_a.compare_count), 32'd5);

    // Recovery keeps the sticky flag
    step("recover", 0, 1, 4'hF, 4'hF);
    chk("recover.chk", 32'(bus_a.check_data_out), 32'd1);
    chk("recover.stk", 32'(bus_a.error_sticky), 32'd1);

    // Disabled edges hold everything
    for (int i = 0; i < 4; i++) step("hold", 0, 0, 4'h1, 4'h2);
    chk("hold.chk", 32'(bus_a.check_data_out), 32'd1);
    chk("hold.cmp", 32'(bus_a.compare_count), 32'd6);

    // Saturation of the 4-bit instance
    step("sat_rst", 1, 0, 4'h0, 4'h0);
    for (int i = 0; i < 20; i++) step("sat", 0, 1, 4'(i), 4'(i + 1));
    chk("sat.b.mis",  32'(bus_b.mismatch_count), 32'd15);
    chk("sat.b.cmp",  32'(bus_b.compare_count), 32'd15);
    chk("sat.b.fidx", 32'(bus_b.first_idx), 32'd0);
    chk("sat.a.cmp",  32'(bus_a.compare_count), 32'd20);

    // Reset wins over an enabled mismatch, then capture re-arms
    step("midrst", 1, 1, 4'h9, 4'h6);
    chk("midrst.mis", 32'(bus_a.mismatch_count), 32'd0);
    chk("midrst.fc",  32'(bus_a.first_c), 32'd0);
    step("rearm", 0, 1, 4'h3, 4'h4);
    chk("rearm.fc",   32'(bus_a.first_c), 32'h3);
    chk("rearm.fe",   32'(bus_a.first_e), 32'h4);
    chk("rearm.fidx", 32'(bus_a.first_idx), 32'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rrst = ($urandom_range(0, 39) == 0);
      ren  = ($urandom_range(0, 3) != 0);
      rc   = 4'($urandom);
      re   = $urandom_range(0, 1) ? rc : 4'($urandom);
      step("rand", rrst, ren, rc, re);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
